// File: rtl/pwm_pkg.sv
// Shared types and defaults for the LED PWM duty sequencer.
package pwm_pkg;

  typedef enum logic [1:0] {
    MODE_ROTATE  = 2'd0,
    MODE_BREATHE = 2'd1,
    MODE_HOLD    = 2'd2
  } mode_e;

  typedef enum logic {
    S_IDLE = 1'b0,
    S_RUN  = 1'b1
  } state_e;

  localparam int N_CH_DEF   = 10;
  localparam int PERIOD_DEF = 100;
  localparam int DUTY_W_DEF = $clog2(PERIOD_DEF + 1);

  // Duty word for the default period; parameterized instances size their own.
  typedef logic [DUTY_W_DEF-1:0] duty_t;

  // Raw mode pins to pattern kind; both upper encodings mean hold.
  function automatic mode_e decode_mode(input logic [1:0] m);
    case (m)
      2'd0:    return MODE_ROTATE;
      2'd1:    return MODE_BREATHE;
      default: return MODE_HOLD;
    endcase
  endfunction

endpackage

// File: rtl/pwm_out_bank.sv
// Shared PWM period counter and per-channel comparators with registered outputs.
module pwm_out_bank #(
  parameter int N_CH   = 10,
  parameter int PERIOD = 100,
  parameter int DW     = $clog2(PERIOD + 1)
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic [N_CH-1:0][DW-1:0]   duty,
  output logic [N_CH-1:0]           pwm_o
);

  logic [DW-1:0]   per_cnt_q, per_cnt_d;
  logic [N_CH-1:0] pwm_q, pwm_d;

  // Period counter wraps at PERIOD-1; duty 0 never matches, duty PERIOD always does.
  always_comb begin
    per_cnt_d = (per_cnt_q == DW'(PERIOD - 1)) ? '0 : per_cnt_q + DW'(1);
    pwm_d     = '0;
    for (int i = 0; i < N_CH; i++) pwm_d[i] = (per_cnt_q < duty[i]);
  end

  // Counter and output register; outputs drive board pins directly.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      per_cnt_q <= '0;
      pwm_q     <= '0;
    end else begin
      per_cnt_q <= per_cnt_d;
      pwm_q     <= pwm_d;
    end
  end

  assign pwm_o = pwm_q;

endmodule

// File: rtl/pwm_duty_sequencer.sv
// Duty-table owner: step-rate FSM/divider, rotate/breathe/hold patterns, cfg write port.
module pwm_duty_sequencer
  import pwm_pkg::*;
#(
  parameter int N_CH     = N_CH_DEF,
  parameter int PERIOD   = PERIOD_DEF,
  parameter int STEP_DIV = 25_000_000,
  parameter int BR_INC   = 10
) (
  input  logic                          clk,
  input  logic                          rst_n,
  input  logic                          en,
  input  logic                          dir,
  input  logic [1:0]                    mode,
  input  logic                          cfg_valid,
  output logic                          cfg_ready,
  input  logic [3:0]                    cfg_ch,
  input  logic [$clog2(PERIOD+1)-1:0]   cfg_duty,
  output logic                          cfg_err,
  output logic                          step,
  output logic [N_CH-1:0]               pwm_o
);

  localparam int DW = $clog2(PERIOD + 1);
  localparam int CW = $clog2(STEP_DIV);

  typedef logic [N_CH-1:0][DW-1:0] table_t;

  // Power-on ramp: channel i starts at i*PERIOD/N_CH.
  function automatic table_t reset_table();
    table_t t;
    for (int i = 0; i < N_CH; i++) t[i] = DW'(i * PERIOD / N_CH);
    return t;
  endfunction

  state_e        state_q, state_d;
  mode_e         last_mode_q, last_mode_d;
  mode_e         mode_cur;
  logic [CW-1:0] div_q, div_d;
  table_t        duty_q, duty_d;
  table_t        rot_l, rot_r, br_val;
  logic          br_up_q, br_up_d;
  logic          step_q, step_d;
  logic          err_q, err_d;
  logic          tick, up, hit_top, hit_bot;

  assign cfg_ready = rst_n;

  // Candidate tables for every pattern; the next-state block picks one on tick.
  always_comb begin
    logic [DW:0] sum, diff;
    sum      = '0;
    diff     = '0;
    mode_cur = decode_mode(mode);
    tick     = (state_q == S_RUN) && en && (div_q == CW'(STEP_DIV - 1));
    // Re-entering breathe always starts by ramping up.
    up       = (last_mode_q != MODE_BREATHE) ? 1'b1 : br_up_q;
    hit_top  = 1'b0;
    hit_bot  = 1'b0;
    rot_l    = '0;
    rot_r    = '0;
    br_val   = '0;
    for (int i = 0; i < N_CH; i++) begin
      rot_l[i] = duty_q[(i + 1) % N_CH];
      rot_r[i] = duty_q[(i + N_CH - 1) % N_CH];
      sum      = {1'b0, duty_q[i]} + (DW+1)'(BR_INC);
      diff     = {1'b0, duty_q[i]} - (DW+1)'(BR_INC);
      if (up) br_val[i] = (sum > (DW+1)'(PERIOD)) ? DW'(PERIOD) : sum[DW-1:0];
      else    br_val[i] = diff[DW] ? '0 : diff[DW-1:0];
      hit_top = hit_top | (br_val[i] == DW'(PERIOD));
      hit_bot = hit_bot | (br_val[i] == '0);
    end
  end

  // FSM, divider, pattern step, then cfg write (write overrides the stepped table).
  always_comb begin
    state_d     = state_q;
    div_d       = div_q;
    duty_d      = duty_q;
    br_up_d     = br_up_q;
    last_mode_d = last_mode_q;
    step_d      = tick;
    err_d       = 1'b0;
    case (state_q)
      S_IDLE: begin
        div_d = '0;
        if (en) state_d = S_RUN;
      end
      S_RUN: begin
        if (!en) begin
          state_d = S_IDLE;
          div_d   = '0;
        end else begin
          div_d = tick ? '0 : div_q + CW'(1);
        end
      end
      default: state_d = S_IDLE;
    endcase
    if (tick) begin
      last_mode_d = mode_cur;
      case (mode_cur)
        MODE_ROTATE:  duty_d = dir ? rot_l : rot_r;
        MODE_BREATHE: begin
          duty_d  = br_val;
          br_up_d = up ? !hit_top : hit_bot;
        end
        default: ;
      endcase
    end
    if (cfg_valid && cfg_ready) begin
      if (int'(cfg_ch) >= N_CH) err_d = 1'b1;
      else begin
        for (int i = 0; i < N_CH; i++)
          if (cfg_ch == 4'(i))
            duty_d[i] = (cfg_duty > DW'(PERIOD)) ? DW'(PERIOD) : cfg_duty;
      end
    end
  end

  // State register; async reset drops any in-flight step or write.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= S_IDLE;
      div_q       <= '0;
      duty_q      <= reset_table();
      br_up_q     <= 1'b1;
      last_mode_q <= MODE_ROTATE;
      step_q      <= 1'b0;
      err_q       <= 1'b0;
    end else begin
      state_q     <= state_d;
      div_q       <= div_d;
      duty_q      <= duty_d;
      br_up_q     <= br_up_d;
      last_mode_q <= last_mode_d;
      step_q      <= step_d;
      err_q       <= err_d;
    end
  end

  assign step    = step_q;
  assign cfg_err = err_q;

  pwm_out_bank #(.N_CH(N_CH), .PERIOD(PERIOD), .DW(DW)) u_bank (
    .clk   (clk),
    .rst_n (rst_n),
    .duty  (duty_q),
    .pwm_o (pwm_o)
  );

endmodule

// File: tb/tb_pwm_duty_sequencer.sv
// Scoreboard bench: a cycle-level reference model queues expected outputs, a monitor compares.
module tb_pwm_duty_sequencer;

  localparam int N_CH = 10, PERIOD = 10, STEP_DIV = 4, BR_INC = 3;
  localparam int DW = $clog2(PERIOD + 1);

  logic clk = 1'b0, rst_n = 1'b0, en = 1'b0, dir = 1'b0;
  logic [1:0] mode = 2'd0;
  logic cfg_valid = 1'b0;
  logic [3:0] cfg_ch = '0;
  logic [DW-1:0] cfg_duty = '0;
  logic cfg_ready, cfg_err, step;
  logic [N_CH-1:0] pwm_o;

  always #5 clk = ~clk;

  pwm_duty_sequencer #(.N_CH(N_CH), .PERIOD(PERIOD), .STEP_DIV(STEP_DIV), .BR_INC(BR_INC)) dut (
    .clk(clk), .rst_n(rst_n), .en(en), .dir(dir), .mode(mode),
    .cfg_valid(cfg_valid), .cfg_ready(cfg_ready), .cfg_ch(cfg_ch), .cfg_duty(cfg_duty),
    .cfg_err(cfg_err), .step(step), .pwm_o(pwm_o)
  );

  typedef struct packed {
    logic [N_CH-1:0] pwm;
    logic            step;
    logic            err;
  } exp_t;

  exp_t exp_q[$];
  int checks = 0, failures = 0;
  int steps_exp = 0, steps_seen = 0;

  // Reference model state: plain integers, rules applied directly.
  int duty_m[N_CH];
  bit running, up, prev_breathe;
  int run_cyc, cyc;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s @%0t: got %0h expected %0h", name, $time, act, exp);
    end
  endtask

  task automatic model_reset();
    for (int i = 0; i < N_CH; i++) duty_m[i] = i * PERIOD / N_CH;
    running = 0; run_cyc = 0; cyc = 0; up = 1; prev_breathe = 0;
    exp_q.delete();
  endtask

  // Model: one update per clock, expected post-edge outputs pushed to the queue.
  always @(posedge clk or negedge rst_n) begin : model_blk
    exp_t e;
    int nxt[N_CH];
    bit tick, any_top, any_bot;
    if (!rst_n) model_reset();
    else begin
      for (int i = 0; i < N_CH; i++) e.pwm[i] = ((cyc % PERIOD) < duty_m[i]);
      tick   = running && en && (run_cyc % STEP_DIV == STEP_DIV - 1);
      e.step = tick;
      e.err  = cfg_valid && (int'(cfg_ch) >= N_CH);
      if (tick) begin
        steps_exp++;
        if (mode == 2'd0) begin
          for (int i = 0; i < N_CH; i++)
            nxt[i] = dir ? duty_m[(i + 1) % N_CH] : duty_m[(i + N_CH - 1) % N_CH];
          duty_m = nxt;
        end else if (mode == 2'd1) begin
          if (!prev_breathe) up = 1;
          any_top = 0; any_bot = 0;
          for (int i = 0; i < N_CH; i++) begin
            duty_m[i] = up ? ((duty_m[i] + BR_INC > PERIOD) ? PERIOD : duty_m[i] + BR_INC)
                           : ((duty_m[i] - BR_INC < 0) ? 0 : duty_m[i] - BR_INC);
            if (duty_m[i] == PERIOD) any_top = 1;
            if (duty_m[i] == 0) any_bot = 1;
          end
          if (up && any_top) up = 0;
          else if (!up && any_bot) up = 1;
        end
        prev_breathe = (mode == 2'd1);
      end
      if (cfg_valid && int'(cfg_ch) < N_CH)
        duty_m[cfg_ch] = (int'(cfg_duty) > PERIOD) ? PERIOD : int'(cfg_duty);
      if (running && en) run_cyc++;
      else begin running = en; run_cyc = 0; end
      cyc++;
      exp_q.push_back(e);
    end
  end

  // Monitor: compare DUT outputs against the queued expectation away from the active edge.
  always @(negedge clk) begin : mon_blk
    exp_t e;
    if (!rst_n) begin
      chk("reset_outputs", {cfg_ready, cfg_err, step, pwm_o}, '0);
    end else begin
      chk("cfg_ready", cfg_ready, 1'b1);
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        chk("pwm_o", pwm_o, e.pwm);
        chk("step", step, e.step);
        chk("cfg_err", cfg_err, e.err);
        if (step) steps_seen++;
      end
    end
  end

  task automatic cfg_write(input int ch, input int d);
    cfg_valid = 1'b1; cfg_ch = 4'(ch); cfg_duty = DW'(d);
    @(negedge clk);
    cfg_valid = 1'b0;
  endtask

  initial begin
    // Reset, then idle with the power-on ramp.
    repeat (3) @(negedge clk);
    #2 rst_n = 1'b1;
    repeat (25) @(negedge clk);
    // Rotate toward ch0 for a full revolution, then the other way.
    mode = 2'd0; dir = 1'b1; en = 1'b1;
    repeat (44) @(negedge clk);
    dir = 1'b0;
    repeat (12) @(negedge clk);
    // Breathe from an all-9 table.
    en = 1'b0;
    @(negedge clk);
    for (int ch = 0; ch < N_CH; ch++) cfg_write(ch, 9);
    mode = 2'd1; en = 1'b1;
    repeat (30) @(negedge clk);
    // Saturating write and out-of-range channel, frozen then in hold.
    en = 1'b0; mode = 2'd2;
    cfg_write(3, 15);
    cfg_write(12, 4);
    repeat (20) @(negedge clk);
    en = 1'b1;
    repeat (12) @(negedge clk);
    // Write coincident with a rotate tick.
    en = 1'b0;
    @(negedge clk);
    mode = 2'd0; dir = 1'b1; en = 1'b1;
    repeat (4) @(negedge clk);
    cfg_write(0, 5);
    repeat (12) @(negedge clk);
    // Async reset with div_cnt at 2 and a write in flight.
    en = 1'b0;
    @(negedge clk);
    en = 1'b1;
    repeat (3) @(negedge clk);
    cfg_valid = 1'b1; cfg_ch = 4'd1; cfg_duty = DW'(7);
    #2 rst_n = 1'b0;
    @(negedge clk);
    @(negedge clk);
    cfg_valid = 1'b0;
    #2 rst_n = 1'b1;
    repeat (20) @(negedge clk);
    // Randomized traffic across modes, directions, enables and writes.
    repeat (600) begin
      en = ($urandom_range(0, 9) != 0);
      if ($urandom_range(0, 7) == 0) mode = 2'($urandom_range(0, 3));
      if ($urandom_range(0, 7) == 0) dir = 1'($urandom_range(0, 1));
      cfg_valid = ($urandom_range(0, 3) == 0);
      cfg_ch    = 4'($urandom_range(0, 15));
      cfg_duty  = DW'($urandom_range(0, 15));
      @(negedge clk);
    end
    cfg_valid = 1'b0;
    repeat (3) @(negedge clk);
    #1;
    chk("step_count", 64'(steps_seen), 64'(steps_exp));
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
